// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: ALU encodings, tag/ROB widths and the
// reservation-station entry layout used by both the ALU issue queue and the LSQ station.
package ooo_pkg;

    localparam int TAG_W  = 6;
    localparam int ROB_W  = 6;
    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_NONE     = 4'd0;
    localparam logic [3:0] ALU_OR       = 4'd1;
    localparam logic [3:0] ALU_ADD      = 4'd2;
    localparam logic [3:0] ALU_XOR      = 4'd3;
    localparam logic [3:0] ALU_SRA      = 4'd4;
    localparam logic [3:0] ALU_PASS_RHS = 4'd5;

    typedef struct packed {
        logic [3:0]        alu_ctrl;
        logic              alu_src;
        logic              is_for_lsq;
        logic [DATA_W-1:0] imm;
        logic [TAG_W-1:0]  rs1_tag;
        logic              rs1_rdy;
        logic [DATA_W-1:0] rs1_val;
        logic [TAG_W-1:0]  rs2_tag;
        logic              rs2_rdy;
        logic [DATA_W-1:0] rs2_val;
        logic [TAG_W-1:0]  dst_tag;
        logic [ROB_W-1:0]  rob_index;
    } iq_entry_t;

    function automatic logic alu_ctrl_valid(input logic [3:0] ctrl);
        return ctrl <= ALU_PASS_RHS;
    endfunction

endpackage

// File: rtl/iq_select.sv
// Issue select: each available FU port, in port order, grabs the lowest-index
// eligible entry that an earlier port has not already taken.
module iq_select #(
    parameter int DEPTH  = 16,
    parameter int NUM_FU = 3
) (
    input  logic [DEPTH-1:0]             eligible,
    input  logic [NUM_FU-1:0]            available,
    output logic [NUM_FU-1:0][DEPTH-1:0] grant
);

    logic [DEPTH-1:0] remaining;
    logic [DEPTH-1:0] pick;

    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        remaining = eligible;
        pick      = '0;
        grant     = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (available[k]) begin
                pick      = remaining & (~remaining + DEPTH'(1));
                grant[k]  = pick;
                remaining = remaining & ~pick;
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// ALU reservation station: buffers renamed ops, snoops FU wakeup buses for
// operand values and dispatches ready ops onto up to NUM_FU functional units.
module issue_queue
    import ooo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int NUM_FU = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ins_valid,
    input  logic [3:0]               ins_alu_ctrl,
    input  logic                     ins_alu_src,
    input  logic                     ins_is_for_lsq,
    input  logic [31:0]              ins_imm,
    input  logic [TAG_W-1:0]         ins_rs1_tag,
    input  logic [TAG_W-1:0]         ins_rs2_tag,
    input  logic                     ins_rs1_rdy,
    input  logic                     ins_rs2_rdy,
    input  logic [31:0]              ins_rs1_val,
    input  logic [31:0]              ins_rs2_val,
    input  logic [TAG_W-1:0]         ins_dst_tag,
    input  logic [ROB_W-1:0]         ins_rob_index,
    output logic                     full,
    input  logic [NUM_FU-1:0]        wk_active,
    input  logic [NUM_FU*TAG_W-1:0]  wk_tag,
    input  logic [NUM_FU*32-1:0]     wk_value,
    input  logic [NUM_FU-1:0]        fu_available,
    output logic [NUM_FU-1:0]        fu_we,
    output logic [NUM_FU*4-1:0]      fu_alu_ctrl,
    output logic [NUM_FU-1:0]        fu_alu_src,
    output logic [NUM_FU-1:0]        fu_is_for_lsq,
    output logic [NUM_FU*32-1:0]     fu_imm,
    output logic [NUM_FU*32-1:0]     fu_rs1_val,
    output logic [NUM_FU*32-1:0]     fu_rs2_val,
    output logic [NUM_FU*TAG_W-1:0]  fu_tag,
    output logic [NUM_FU*ROB_W-1:0]  fu_rob_index
);

    iq_entry_t                    entries     [DEPTH];
    iq_entry_t                    entries_nxt [DEPTH];
    iq_entry_t                    ins_entry;
    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0]             eligible;
    logic [DEPTH-1:0]             issued;
    logic [DEPTH-1:0]             free_onehot;
    logic [NUM_FU-1:0][DEPTH-1:0] grant;
    logic                         ins_fire;

    // Returns {rdy, value}; lowest-numbered matching bus wins when several match.
    function automatic logic [32:0] snoop(
        input logic [TAG_W-1:0]        tag,
        input logic                    rdy,
        input logic [31:0]             val,
        input logic [NUM_FU-1:0]       act,
        input logic [NUM_FU*TAG_W-1:0] tags,
        input logic [NUM_FU*32-1:0]    vals
    );
        logic [32:0] r;
        r = {rdy, val};
        if (!rdy) begin
            for (int k = NUM_FU - 1; k >= 0; k--) begin
                if (act[k] && tags[k*TAG_W +: TAG_W] == tag) r = {1'b1, vals[k*32 +: 32]};
            end
        end
        return r;
    endfunction

    assign full        = &valid_q;
    assign ins_fire    = ins_valid && !full;
    assign free_onehot = ~valid_q & (valid_q + DEPTH'(1));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            eligible[i] = valid_q[i] && entries[i].rs1_rdy
                          && (entries[i].alu_src || entries[i].rs2_rdy);
        end
    end

    iq_select #(.DEPTH(DEPTH), .NUM_FU(NUM_FU)) u_select (
        .eligible  (eligible),
        .available (fu_available),
        .grant     (grant)
    );

    always_comb begin
        issued = '0;
        for (int k = 0; k < NUM_FU; k++) issued = issued | grant[k];
    end

    // The incoming op snoops the buses too, so a wakeup in its insert cycle is not lost.
    always_comb begin
        ins_entry.alu_ctrl   = ins_alu_ctrl;
        ins_entry.alu_src    = ins_alu_src;
        ins_entry.is_for_lsq = ins_is_for_lsq;
        ins_entry.imm        = ins_imm;
        ins_entry.rs1_tag    = ins_rs1_tag;
        ins_entry.rs2_tag    = ins_rs2_tag;
        ins_entry.dst_tag    = ins_dst_tag;
        ins_entry.rob_index  = ins_rob_index;
        {ins_entry.rs1_rdy, ins_entry.rs1_val} =
            snoop(ins_rs1_tag, ins_rs1_rdy, ins_rs1_val, wk_active, wk_tag, wk_value);
        {ins_entry.rs2_rdy, ins_entry.rs2_val} =
            snoop(ins_rs2_tag, ins_rs2_rdy, ins_rs2_val, wk_active, wk_tag, wk_value);

        for (int i = 0; i < DEPTH; i++) begin
            entries_nxt[i] = entries[i];
            {entries_nxt[i].rs1_rdy, entries_nxt[i].rs1_val} =
                snoop(entries[i].rs1_tag, entries[i].rs1_rdy, entries[i].rs1_val,
                      wk_active, wk_tag, wk_value);
            {entries_nxt[i].rs2_rdy, entries_nxt[i].rs2_val} =
                snoop(entries[i].rs2_tag, entries[i].rs2_rdy, entries[i].rs2_val,
                      wk_active, wk_tag, wk_value);
            if (ins_fire && free_onehot[i]) entries_nxt[i] = ins_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) valid_q <= '0;
        else       valid_q <= (valid_q & ~issued) | (ins_fire ? free_onehot : '0);
    end

    // NOTE: the payload array is not reset; valid_q gates every use, which keeps the array plain storage.
    always_ff @(posedge clk) begin
        entries <= entries_nxt;
    end

    // One-hot grants make each slice a simple AND-OR mux; unused slices stay zero.
    always_comb begin
        fu_we         = '0;
        fu_alu_ctrl   = '0;
        fu_alu_src    = '0;
        fu_is_for_lsq = '0;
        fu_imm        = '0;
        fu_rs1_val    = '0;
        fu_rs2_val    = '0;
        fu_tag        = '0;
        fu_rob_index  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            fu_we[k] = |grant[k];
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[k][i]) begin
                    fu_alu_ctrl[k*4 +: 4]          = entries[i].alu_ctrl;
                    fu_alu_src[k]                  = entries[i].alu_src;
                    fu_is_for_lsq[k]               = entries[i].is_for_lsq;
                    fu_imm[k*32 +: 32]             = entries[i].imm;
                    fu_rs1_val[k*32 +: 32]         = entries[i].rs1_val;
                    fu_rs2_val[k*32 +: 32]         = entries[i].rs2_val;
                    fu_tag[k*TAG_W +: TAG_W]       = entries[i].dst_tag;
                    fu_rob_index[k*ROB_W +: ROB_W] = entries[i].rob_index;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && ins_valid) begin
            assert (!full) else $fatal(1, "issue_queue: insert while full");
            assert (alu_ctrl_valid(ins_alu_ctrl)) else $fatal(1, "issue_queue: bad ALU control");
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue: insert/issue, wakeup capture,
// multi-FU select, full handling and mid-stream reset.
module tb_issue_queue;
    import ooo_pkg::*;

    localparam int DEPTH  = 16;
    localparam int NUM_FU = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    ins_valid;
    logic [3:0]              ins_alu_ctrl;
    logic                    ins_alu_src;
    logic                    ins_is_for_lsq;
    logic [31:0]             ins_imm;
    logic [TAG_W-1:0]        ins_rs1_tag, ins_rs2_tag;
    logic                    ins_rs1_rdy, ins_rs2_rdy;
    logic [31:0]             ins_rs1_val, ins_rs2_val;
    logic [TAG_W-1:0]        ins_dst_tag;
    logic [ROB_W-1:0]        ins_rob_index;
    logic                    full;
    logic [NUM_FU-1:0]       wk_active;
    logic [NUM_FU*TAG_W-1:0] wk_tag;
    logic [NUM_FU*32-1:0]    wk_value;
    logic [NUM_FU-1:0]       fu_available;
    logic [NUM_FU-1:0]       fu_we;
    logic [NUM_FU*4-1:0]     fu_alu_ctrl;
    logic [NUM_FU-1:0]       fu_alu_src, fu_is_for_lsq;
    logic [NUM_FU*32-1:0]    fu_imm, fu_rs1_val, fu_rs2_val;
    logic [NUM_FU*TAG_W-1:0] fu_tag;
    logic [NUM_FU*ROB_W-1:0] fu_rob_index;

    int total = 0;
    int bad   = 0;

    issue_queue #(.DEPTH(DEPTH), .NUM_FU(NUM_FU)) dut (
        .clk(clk), .reset(reset),
        .ins_valid(ins_valid), .ins_alu_ctrl(ins_alu_ctrl), .ins_alu_src(ins_alu_src),
        .ins_is_for_lsq(ins_is_for_lsq), .ins_imm(ins_imm),
        .ins_rs1_tag(ins_rs1_tag), .ins_rs2_tag(ins_rs2_tag),
        .ins_rs1_rdy(ins_rs1_rdy), .ins_rs2_rdy(ins_rs2_rdy),
        .ins_rs1_val(ins_rs1_val), .ins_rs2_val(ins_rs2_val),
        .ins_dst_tag(ins_dst_tag), .ins_rob_index(ins_rob_index),
        .full(full),
        .wk_active(wk_active), .wk_tag(wk_tag), .wk_value(wk_value),
        .fu_available(fu_available),
        .fu_we(fu_we), .fu_alu_ctrl(fu_alu_ctrl), .fu_alu_src(fu_alu_src),
        .fu_is_for_lsq(fu_is_for_lsq), .fu_imm(fu_imm),
        .fu_rs1_val(fu_rs1_val), .fu_rs2_val(fu_rs2_val),
        .fu_tag(fu_tag), .fu_rob_index(fu_rob_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [3:0] ctrl, input logic src, input logic [31:0] imm,
                       input logic [TAG_W-1:0] t1, input logic r1, input logic [31:0] v1,
                       input logic [TAG_W-1:0] t2, input logic r2, input logic [31:0] v2,
                       input logic [ROB_W-1:0] rob);
        ins_valid     = 1'b1;
        ins_alu_ctrl  = ctrl;
        ins_alu_src   = src;
        ins_imm       = imm;
        ins_rs1_tag   = t1;
        ins_rs1_rdy   = r1;
        ins_rs1_val   = v1;
        ins_rs2_tag   = t2;
        ins_rs2_rdy   = r2;
        ins_rs2_val   = v2;
        ins_dst_tag   = TAG_W'(rob + 1);
        ins_rob_index = rob;
    endtask

    task automatic wake(input int k, input logic [TAG_W-1:0] t, input logic [31:0] v);
        wk_active[k]               = 1'b1;
        wk_tag[k*TAG_W +: TAG_W]   = t;
        wk_value[k*32 +: 32]       = v;
    endtask

    task automatic clear_inputs();
        ins_valid = 1'b0;
        wk_active = '0;
        wk_tag    = '0;
        wk_value  = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    function automatic logic [31:0] s32(input logic [NUM_FU*32-1:0] v, input int k);
        return v[k*32 +: 32];
    endfunction

    initial begin
        reset = 1'b1;
        ins(ALU_NONE, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        clear_inputs();
        fu_available = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_full", full, 0);
        check("rst_we", fu_we, 0);
        check("rst_data", fu_rs1_val, 0);

        // 1: ready ADD issues one cycle after insert, then entry is gone
        fu_available = 3'b111;
        ins(ALU_ADD, 1'b0, 32'h0, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7, 6'd11);
        tick();
        clear_inputs();
        check("t1_we", fu_we, 3'b001);
        check("t1_rs1", s32(fu_rs1_val, 0), 5);
        check("t1_rs2", s32(fu_rs2_val, 0), 7);
        check("t1_ctrl", fu_alu_ctrl[3:0], ALU_ADD);
        check("t1_rob", fu_rob_index[ROB_W-1:0], 11);
        check("t1_tag", fu_tag[TAG_W-1:0], 12);
        tick();
        check("t1_freed", fu_we, 0);

        // 2: rs1 waits on tag 9, woken by bus 1 two cycles later
        ins(ALU_OR, 1'b0, 32'h0, 6'd9, 1'b0, 32'h0, 6'd3, 1'b1, 32'd3, 6'd12);
        tick();
        clear_inputs();
        check("t2_wait0", fu_we, 0);
        tick();
        check("t2_wait1", fu_we, 0);
        wake(1, 6'd9, 32'h10);
        tick();
        clear_inputs();
        check("t2_we", fu_we, 3'b001);
        check("t2_rs1", s32(fu_rs1_val, 0), 32'h10);
        check("t2_ctrl", fu_alu_ctrl[3:0], ALU_OR);
        tick();
        check("t2_freed", fu_we, 0);

        // 3: same-cycle wakeup on bus 2 captured by the op being inserted
        ins(ALU_XOR, 1'b0, 32'h0, 6'd5, 1'b1, 32'h1, 6'd4, 1'b0, 32'h0, 6'd13);
        wake(2, 6'd4, 32'hAB);
        tick();
        clear_inputs();
        check("t3_we", fu_we, 3'b001);
        check("t3_rs2", s32(fu_rs2_val, 0), 32'hAB);
        tick();

        // alu_src=1 ignores a not-ready rs2
        fu_available = 3'b001;
        ins(ALU_SRA, 1'b1, 32'h1234, 6'd6, 1'b1, 32'h77, 6'd20, 1'b0, 32'h0, 6'd14);
        ins_is_for_lsq = 1'b1;
        tick();
        clear_inputs();
        ins_is_for_lsq = 1'b0;
        check("imm_we", fu_we, 3'b001);
        check("imm_imm", s32(fu_imm, 0), 32'h1234);
        check("imm_src", fu_alu_src, 3'b001);
        check("imm_lsq", fu_is_for_lsq, 3'b001);
        tick();

        // 4: two eligible entries onto FU1 and FU2
        fu_available = 3'b000;
        ins(ALU_ADD, 1'b0, 32'h0, 6'd1, 1'b1, 32'h11, 6'd1, 1'b1, 32'h0, 6'd20);
        tick();
        ins(ALU_ADD, 1'b0, 32'h0, 6'd1, 1'b1, 32'h22, 6'd1, 1'b1, 32'h0, 6'd21);
        tick();
        clear_inputs();
        check("t4_hold", fu_we, 0);
        fu_available = 3'b110;
        #1;
        check("t4_we", fu_we, 3'b110);
        check("t4_fu1", s32(fu_rs1_val, 1), 32'h11);
        check("t4_fu2", s32(fu_rs1_val, 2), 32'h22);
        check("t4_fu0", s32(fu_rs1_val, 0), 0);
        check("t4_rob2", fu_rob_index[2*ROB_W +: ROB_W], 21);
        tick();
        check("t4_freed", fu_we, 0);

        // 5: fill to full, wake and issue entry 3, refill the freed slot
        fu_available = 3'b000;
        for (int i = 0; i < DEPTH; i++) begin
            ins(ALU_PASS_RHS, 1'b1, 32'(i), TAG_W'(10 + i), 1'b0, 32'h0, 6'd0, 1'b0, 32'h0,
                ROB_W'(i));
            tick();
            if (i == DEPTH - 2) check("t5_not_full", full, 0);
        end
        clear_inputs();
        check("t5_full", full, 1);
        wake(0, 6'd13, 32'h99);
        tick();
        clear_inputs();
        fu_available = 3'b001;
        #1;
        check("t5_we", fu_we, 3'b001);
        check("t5_rob", fu_rob_index[ROB_W-1:0], 3);
        check("t5_rs1", s32(fu_rs1_val, 0), 32'h99);
        check("t5_full_issuing", full, 1);
        tick();
        fu_available = 3'b000;
        check("t5_freed", full, 0);
        ins(ALU_ADD, 1'b1, 32'h0, 6'd0, 1'b1, 32'h5, 6'd0, 1'b0, 32'h0, 6'd40);
        tick();
        clear_inputs();
        check("t5_refull", full, 1);
        fu_available = 3'b001;
        #1;
        check("t5_new_rob", fu_rob_index[ROB_W-1:0], 40);
        tick();
        fu_available = 3'b000;
        check("t5_drain", full, 0);

        // 6: reset mid-stream discards all held ops
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            ins(ALU_OR, 1'b1, 32'h0, TAG_W'(30 + i), 1'b0, 32'h0, 6'd0, 1'b0, 32'h0,
                ROB_W'(i));
            tick();
        end
        clear_inputs();
        pulse_reset();
        check("t6_full", full, 0);
        check("t6_we", fu_we, 0);
        fu_available = 3'b111;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < NUM_FU; k++) wake(k, TAG_W'(30 + 3 * c + k), 32'hDEAD);
            tick();
            clear_inputs();
            check("t6_no_issue", fu_we, 0);
        end
        ins(ALU_ADD, 1'b0, 32'h0, 6'd1, 1'b1, 32'h3C, 6'd1, 1'b1, 32'h0, 6'd50);
        tick();
        clear_inputs();
        check("t6_alive_we", fu_we, 3'b001);
        check("t6_alive_rob", fu_rob_index[ROB_W-1:0], 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
